// File: rtl/motor_deadtime_gate_pkg.sv
// Shared types and bit-layout constants for the motor dead-time gate.
package motor_pkg;

  typedef enum logic [1:0] {
    PH_OFF,
    PH_HI,
    PH_LO,
    PH_DEAD
  } phase_state_t;

  localparam int unsigned K_NPHASES = 3;
  localparam int unsigned K_PATW    = 2 * K_NPHASES;

  // Pattern layout: high side of phase k at K_HI_BASE+k, low side at K_LO_BASE+k.
  localparam int unsigned K_HI_BASE = 0;
  localparam int unsigned K_LO_BASE = K_NPHASES;

endpackage

// File: rtl/motor_deadtime_gate_if.sv
// Pattern-in / gate-command-out bundle of the dead-time gate.
// Optional min-on parameter present when MOTOR_DEADTIME_MIN_ON_EN is defined.
interface motor_deadtime_gate_if #(
  parameter int unsigned K_DTWIDTH = 8
);
  import motor_pkg::*;

  logic                  i_enable;
  logic [K_PATW-1:0]     i_pattern;
  logic [K_DTWIDTH-1:0]  i_param_deadtime;
`ifdef MOTOR_DEADTIME_MIN_ON_EN
  logic [K_DTWIDTH-1:0]  i_param_min_on;
`endif
  logic                  i_fault_clear;
  logic [K_PATW-1:0]     o_cmd;
  logic                  o_shoot_through;
  logic                  o_busy;

  modport master (
`ifdef MOTOR_DEADTIME_MIN_ON_EN
    output i_param_min_on,
`endif
    output i_enable,
    output i_pattern,
    output i_param_deadtime,
    output i_fault_clear,
    input  o_cmd,
    input  o_shoot_through,
    input  o_busy
  );

  modport slave (
`ifdef MOTOR_DEADTIME_MIN_ON_EN
    input  i_param_min_on,
`endif
    input  i_enable,
    input  i_pattern,
    input  i_param_deadtime,
    input  i_fault_clear,
    output o_cmd,
    output o_shoot_through,
    output o_busy
  );

endinterface

// File: rtl/motor_deadtime_gate_phase.sv
// One half-bridge: OFF/HI/LO/DEAD state machine with dead-time counter.
// MOTOR_DEADTIME_MIN_ON_EN adds a minimum on-time hold for HI and LO.
module deadtime_phase
  import motor_pkg::*;
#(
  parameter int unsigned K_DTWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MOTOR_DEADTIME_MIN_ON_EN
  input  logic                 enable,
  input  logic [K_DTWIDTH-1:0] min_on,
`endif
  input  logic [1:0]           req,       // {hi, lo}, already gated by enable
  input  logic [K_DTWIDTH-1:0] deadtime,
  output logic                 hi,
  output logic                 lo,
  output logic                 dead,
  output logic                 illegal
);

  localparam logic [K_DTWIDTH-1:0] DtOne  = K_DTWIDTH'(1);
  localparam logic [1:0]           ReqHi  = 2'b10;
  localparam logic [1:0]           ReqLo  = 2'b01;
  localparam logic [1:0]           ReqBad = 2'b11;

  phase_state_t         state_q, state_d;
  logic [K_DTWIDTH-1:0] cnt_q, cnt_d;
  logic [K_DTWIDTH-1:0] dt_load;
  logic [1:0]           req_eff;
  logic                 hold;
  logic                 enter_on;

  assign illegal = (req == ReqBad);
  assign req_eff = illegal ? 2'b00 : req;
  assign dt_load = (deadtime == '0) ? DtOne : deadtime;

`ifdef MOTOR_DEADTIME_MIN_ON_EN
  logic [K_DTWIDTH-1:0] mon_q, mon_d;

  // Hold the on-state while min-on runs, unless disabled or shoot-through requested.
  assign hold = (mon_q > DtOne) && enable && !illegal;

  always_comb begin
    mon_d = mon_q;
    if (enter_on) begin
      mon_d = min_on;
    end else if ((state_q == PH_HI || state_q == PH_LO) && mon_q != '0) begin
      mon_d = mon_q - DtOne;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mon_q <= '0;
    end else begin
      mon_q <= mon_d;
    end
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enter_on = 1'b0;
    unique case (state_q)
      PH_OFF: begin
        if (req_eff == ReqHi) begin
          state_d  = PH_HI;
          enter_on = 1'b1;
        end else if (req_eff == ReqLo) begin
          state_d  = PH_LO;
          enter_on = 1'b1;
        end
      end
      PH_HI: begin
        if (req_eff != ReqHi && !hold) begin
          state_d = PH_DEAD;
          cnt_d   = dt_load;
        end
      end
      PH_LO: begin
        if (req_eff != ReqLo && !hold) begin
          state_d = PH_DEAD;
          cnt_d   = dt_load;
        end
      end
      PH_DEAD: begin
        // The last DEAD cycle is the one holding count 1; leave on its edge.
        if (cnt_q <= DtOne) begin
          cnt_d = '0;
          if (req_eff == ReqHi) begin
            state_d  = PH_HI;
            enter_on = 1'b1;
          end else if (req_eff == ReqLo) begin
            state_d  = PH_LO;
            enter_on = 1'b1;
          end else begin
            state_d  = PH_OFF;
          end
        end else begin
          cnt_d = cnt_q - DtOne;
        end
      end
      default: begin
        state_d = PH_OFF;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PH_OFF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hi   = (state_q == PH_HI);
  assign lo   = (state_q == PH_LO);
  assign dead = (state_q == PH_DEAD);

endmodule

// File: rtl/motor_deadtime_gate.sv
// Three-phase dead-time gate: enable gating, per-phase FSMs, sticky shoot-through flag.
// Build with MOTOR_DEADTIME_MIN_ON_EN for the minimum on-time filter.
module motor_deadtime_gate
  import motor_pkg::*;
#(
  parameter int unsigned K_DTWIDTH = 8
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  motor_deadtime_gate_if.slave bus
);

  logic [K_NPHASES-1:0] ph_hi;
  logic [K_NPHASES-1:0] ph_lo;
  logic [K_NPHASES-1:0] ph_dead;
  logic [K_NPHASES-1:0] ph_illegal;
  logic                 st_q, st_d;

  for (genvar k = 0; k < K_NPHASES; k++) begin : g_phase
    logic [1:0] req;

    // Disabling forces an off request before the shoot-through check.
    assign req = bus.i_enable ?
                 {bus.i_pattern[K_HI_BASE + k], bus.i_pattern[K_LO_BASE + k]} : 2'b00;

    deadtime_phase #(
      .K_DTWIDTH (K_DTWIDTH)
    ) u_phase (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
`ifdef MOTOR_DEADTIME_MIN_ON_EN
      .enable   (bus.i_enable),
      .min_on   (bus.i_param_min_on),
`endif
      .req      (req),
      .deadtime (bus.i_param_deadtime),
      .hi       (ph_hi[k]),
      .lo       (ph_lo[k]),
      .dead     (ph_dead[k]),
      .illegal  (ph_illegal[k])
    );
  end

  // A new illegal request wins over a same-cycle clear.
  assign st_d = (st_q & ~bus.i_fault_clear) | (|ph_illegal);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q <= 1'b0;
    end else begin
      st_q <= st_d;
    end
  end

  assign bus.o_cmd           = {ph_lo, ph_hi};
  assign bus.o_shoot_through = st_q;
  assign bus.o_busy          = |ph_dead;

endmodule

// File: doc/motor_deadtime_gate.md
Name: motor_deadtime_gate

Overview:
Output stage placed directly after the commutation pattern generator and before the gate-driver pins. It takes the 6-bit switch pattern and applies per-half-bridge dead-time, so the high and low switches of a phase are never on together or back-to-back. It also detects illegal shoot-through requests and forces every phase off when disabled. All outputs are registered.

Parameters:
K_DTWIDTH, 8, width of the dead-time counter and of i_param_deadtime.
K_NPHASES, 3, number of half-bridges. Fixed at 3; the pattern is 2*K_NPHASES bits wide.

Ports:
i_clk  input  1  master clock
i_rst_n  input  1  master reset, asynchronous, active-low
i_enable  input  1  when 0, every phase is driven to off through dead-time
i_pattern  input  6  requested pattern; bit k = high side of phase k, bit k+3 = low side of phase k (k=0..2)
i_param_deadtime  input  K_DTWIDTH  dead-time in clock cycles
i_fault_clear  input  1  single-cycle pulse; clears o_shoot_through
o_cmd  output  6  gate commands, same bit mapping as i_pattern
o_shoot_through  output  1  sticky flag: a phase requested high and low at the same time
o_busy  output  1  at least one phase is in DEAD

Behaviour:
- Reset (asynchronous, active-low): all phases in OFF; o_cmd=0; o_shoot_through=0; o_busy=0.
- Per-phase request: req = {hi,lo} taken from i_pattern.
  - If i_enable=0, req is forced to 00.
  - If req=11, it is treated as 00 and o_shoot_through is set.
- Per-phase FSM states:
  - OFF: both switches off; dead-time already satisfied.
    - req=10 goes to HI; req=01 goes to LO.
    - Latency is 1 cycle: pattern change at cycle n appears on o_cmd at cycle n+1.
  - HI (high=1, low=0): any req other than 10 goes to DEAD.
  - LO (high=0, low=1): any req other than 01 goes to DEAD.
  - DEAD (both switches 0):
    - On entry, the counter is loaded with max(i_param_deadtime,1). i_param_deadtime is sampled only on entry.
    - The counter decrements each cycle.
    - When the count reaches 0, req is re-sampled: 10 goes to HI, 01 goes to LO, 00 goes to OFF.
    - Result: the outputs are both 0 for exactly max(deadtime,1) cycles.
    - Changes to req during DEAD do not restart the count.
- Going from off to on never inserts dead-time. Going from on to anything always does, including on to off followed by the opposite side.
- Brake (upstream drives all low sides on) follows the same rules: HI to DEAD to LO.
- Phases are independent; o_busy is the OR of the three DEAD states.
- o_shoot_through is sticky until i_fault_clear. If a new illegal request and i_fault_clear occur in the same cycle, the flag stays 1.
- i_enable falling during DEAD: counting continues, then the phase goes to OFF.
- i_param_deadtime=0 behaves as 1.
- o_cmd is driven from state registers only. There is no combinational path from i_pattern to o_cmd.

Optional Feature:
Macro MOTOR_DEADTIME_MIN_ON_EN.
- With the macro:
  - Adds input i_param_min_on [K_DTWIDTH-1:0].
  - HI or LO holds for at least i_param_min_on cycles after entry before leaving on a request change. This filters narrow PWM slivers.
  - Leaving early is still immediate when i_enable=0 or req=11.
  - A request that reverts to the current state before min-on expires causes no transition.
- Without the macro: the port is absent and HI/LO exit immediately, as described above.

Decomposition:
- Package motor_pkg:
  - typedef enum logic [1:0] phase_state_t {PH_OFF, PH_HI, PH_LO, PH_DEAD}
  - localparam K_NPHASES=3
  - localparam index helpers: high-side bit = k, low-side bit = k+K_NPHASES
- Sub-module deadtime_phase: one half-bridge containing the FSM, the dead counter and the optional min-on counter. Outputs: hi, lo, dead, illegal.
- The top level instantiates 3 copies and holds the sticky fault register, i_enable gating and the o_busy OR.

Test Plan:
- Reset, then pattern 6'b000_001 with deadtime=4: o_cmd=6'b000_001 one cycle later; o_busy=0.
- From phase 0 HI, pattern goes to 6'b001_000 with deadtime=4: o_cmd=0 for exactly 4 cycles with o_busy=1, then o_cmd=6'b001_000.
- Pattern 6'b001_001 (phase 0 illegal): phase 0 goes to DEAD then OFF; o_shoot_through=1 and stays 1; i_fault_clear pulse sets it to 0 the next cycle.
- All phases HI, i_enable dropped with deadtime=3: all outputs 0 immediately, o_busy=1 for 3 cycles, then all OFF; re-enable with pattern 6'b000_010 gives o_cmd=6'b000_010 after 1 cycle.
- deadtime=0, HI to LO: exactly one cycle with both outputs 0; deadtime changed to 10 mid-DEAD has no effect on the current interval.
- With MOTOR_DEADTIME_MIN_ON_EN and min_on=5: a HI request lasting 2 cycles keeps the HI output for 5 cycles, then dead-time is applied before LO.
